// File: rtl/tdm_demux4_pkg.sv
// ============================================================================
// Module      : tdm_demux4_pkg
// Description : Shared definitions for the 1:4 TDM demultiplexer.
//               - state_e   : FSM states (IDLE = partial frame not started,
//                             RUN = frame in progress)
//               - N_SLOTS   : slots per frame
//               - LAST_SLOT : index of the slot that commits a frame
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tdm_demux4_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int         N_SLOTS   = 4;
    localparam logic [1:0] LAST_SLOT = 2'd3;

endpackage

`default_nettype wire

// File: rtl/tdm_demux4_en.sv
// ============================================================================
// Module      : tdm_demux4_en
// Description : Combinational 1:4 enable decoder. Produces a one-hot write
//               enable for slot s when en is high, all zeros otherwise.
// Ports       : en  in  1        decoder enable
//               s   in  2        slot index
//               we  out N_SLOTS  one-hot write enables
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tdm_demux4_en
    import tdm_demux4_pkg::*;
(
    input  logic               en,
    input  logic [1:0]         s,
    output logic [N_SLOTS-1:0] we
);

    always_comb begin
        we = '0;
        if (en) begin
            we[s] = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/tdm_demux4.sv
// ============================================================================
// Module      : tdm_demux4
// Description : Receive-side 1:4 time-division demultiplexer. Beats of a
//               serial slot stream are collected into shadow registers and a
//               complete frame is published atomically to ch0..ch3 with a
//               one-cycle frame_valid strobe. Framing violations (stray beat
//               outside a frame, or a frame_start in mid-frame) pulse
//               frame_err.
// Ports       : clk          in   1   system clock (rising edge)
//               reset        in   1   synchronous active-high reset
//               din          in   DW  slot data beat
//               din_valid    in   1   din carries a beat this cycle
//               frame_start  in   1   current valid beat is slot 0
//               ch0..ch3     out  DW  channels of the last complete frame
//               sel          out  2   slot index of the next valid beat
//               busy         out  1   partial frame in progress
//               frame_valid  out  1   pulse: ch0..ch3 just updated
//               frame_err    out  1   pulse: framing violation
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tdm_demux4
    import tdm_demux4_pkg::*;
#(
    parameter int DW = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] din,
    input  logic          din_valid,
    input  logic          frame_start,
    output logic [DW-1:0] ch0,
    output logic [DW-1:0] ch1,
    output logic [DW-1:0] ch2,
    output logic [DW-1:0] ch3,
    output logic [1:0]    sel,
    output logic          busy,
    output logic          frame_valid,
    output logic          frame_err
);

    state_e        r_state_q, w_state_d;
    logic [1:0]    r_sel_q, w_sel_d;
    logic [DW-1:0] r_sh0_q, w_sh0_d;
    logic [DW-1:0] r_sh1_q, w_sh1_d;
    logic [DW-1:0] r_sh2_q, w_sh2_d;
    logic [DW-1:0] r_ch0_q, w_ch0_d;
    logic [DW-1:0] r_ch1_q, w_ch1_d;
    logic [DW-1:0] r_ch2_q, w_ch2_d;
    logic [DW-1:0] r_ch3_q, w_ch3_d;
    logic          r_fv_q, w_fv_d;
    logic          r_err_q, w_err_d;

    logic [N_SLOTS-1:0] w_we;

    // sel is 0 exactly when the FSM is IDLE, so we[0] marks a beat arriving
    // outside a frame and we[1..3] mark in-frame slot beats.
    tdm_demux4_en u_en (
        .en (din_valid),
        .s  (r_sel_q),
        .we (w_we)
    );

    always_comb begin
        w_state_d = r_state_q;
        w_sel_d   = r_sel_q;
        w_sh0_d   = r_sh0_q;
        w_sh1_d   = r_sh1_q;
        w_sh2_d   = r_sh2_q;
        w_ch0_d   = r_ch0_q;
        w_ch1_d   = r_ch1_q;
        w_ch2_d   = r_ch2_q;
        w_ch3_d   = r_ch3_q;
        w_fv_d    = 1'b0;
        w_err_d   = 1'b0;

        if (din_valid && frame_start) begin
            // Start (or restart) a frame; a restart drops the partial frame.
            w_sh0_d   = din;
            w_sel_d   = 2'd1;
            w_state_d = ST_RUN;
            w_err_d   = (r_state_q == ST_RUN);
        end else if (w_we[0]) begin
            // Stray beat while IDLE: dropped.
            w_err_d = 1'b1;
        end else if (w_we[1]) begin
            w_sh1_d = din;
            w_sel_d = r_sel_q + 2'd1;
        end else if (w_we[2]) begin
            w_sh2_d = din;
            w_sel_d = r_sel_q + 2'd1;
        end else if (w_we[LAST_SLOT]) begin
            w_ch0_d   = r_sh0_q;
            w_ch1_d   = r_sh1_q;
            w_ch2_d   = r_sh2_q;
            w_ch3_d   = din;
            w_fv_d    = 1'b1;
            w_sel_d   = 2'd0;
            w_state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q <= ST_IDLE;
            r_sel_q   <= 2'd0;
            r_sh0_q   <= '0;
            r_sh1_q   <= '0;
            r_sh2_q   <= '0;
            r_ch0_q   <= '0;
            r_ch1_q   <= '0;
            r_ch2_q   <= '0;
            r_ch3_q   <= '0;
            r_fv_q    <= 1'b0;
            r_err_q   <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_sel_q   <= w_sel_d;
            r_sh0_q   <= w_sh0_d;
            r_sh1_q   <= w_sh1_d;
            r_sh2_q   <= w_sh2_d;
            r_ch0_q   <= w_ch0_d;
            r_ch1_q   <= w_ch1_d;
            r_ch2_q   <= w_ch2_d;
            r_ch3_q   <= w_ch3_d;
            r_fv_q    <= w_fv_d;
            r_err_q   <= w_err_d;
        end
    end

    assign ch0         = r_ch0_q;
    assign ch1         = r_ch1_q;
    assign ch2         = r_ch2_q;
    assign ch3         = r_ch3_q;
    assign sel         = r_sel_q;
    assign busy        = (r_state_q == ST_RUN);
    assign frame_valid = r_fv_q;
    assign frame_err   = r_err_q;

endmodule

`default_nettype wire
